// File: rtl/neureka_tcdm_responder_pkg.sv
// -----------------------------------------------------------------------------
// neureka_package
// Shared types and constants for the NEUREKA TCDM responder.
//   resp_entry_t  : one response FIFO entry (read data + echoed ID). It is sized
//                   for the default bus configuration and serves as the FIFO's
//                   default entry type.
//   LFSR_SEED     : reset value of the optional grant-stall LFSR.
//   LFSR_POLY     : Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1.
//   lfsr_next()   : one shift step of that LFSR.
// -----------------------------------------------------------------------------
package neureka_package;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 256;
    localparam int unsigned NEUREKA_TCDM_ID_WIDTH     = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps at stages 16, 14, 13, 11 map to state bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef struct packed {
        logic [NEUREKA_MEM_BANDWIDTH_EXT-1:0] data;
        logic [NEUREKA_TCDM_ID_WIDTH-1:0]     id;
    } resp_entry_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] i_state);
        return {i_state[14:0], ^(i_state & LFSR_POLY)};
    endfunction

endpackage

// File: rtl/neureka_tcdm_resp_fifo.sv
// -----------------------------------------------------------------------------
// neureka_tcdm_resp_fifo
// Ordered response FIFO with fall-through: when empty, an entry being pushed is
// presented at the head in the same cycle, which gives the responder its
// one-cycle minimum latency. If that entry is popped in the same cycle it is
// never stored.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          synchronous flush (wins over push/pop)
//   i_push           push valid, i_push_entry payload
//   i_pop            consumer ready; pops only when o_valid is high
//   o_valid, o_head  head entry (forced to zero while not valid)
//   o_count          number of stored entries (excludes a bypassing push)
// -----------------------------------------------------------------------------
module neureka_tcdm_resp_fifo
    import neureka_package::*;
#(
    parameter type         entry_t = resp_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  entry_t                     i_push_entry,
    input  logic                       i_pop,
    output logic                       o_valid,
    output entry_t                     o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t          r_store [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_write;
    logic            w_pop_store;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i_ptr);
        return (i_ptr == PW'(DEPTH-1)) ? '0 : i_ptr + PW'(1);
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_pop_store = i_pop && !w_empty;
    // A push into an empty FIFO that is popped at once bypasses storage.
    assign w_write     = i_push && !(w_empty && i_pop);

    assign o_valid = !w_empty || i_push;
    assign o_head  = !w_empty ? r_store[r_rptr] : (i_push ? i_push_entry : '0);
    assign o_count = r_count;

    // NOTE: storage arrays carry no reset; validity comes only from the
    // pointers and count, so resetting the payload would buy nothing.
    always_ff @(posedge i_clk) begin
        if (w_write && !i_clear) begin
            r_store[r_wptr] <= i_push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write)     r_wptr <= ptr_inc(r_wptr);
            if (w_pop_store) r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + CW'(w_write) - CW'(w_pop_store);
        end
    end

endmodule

// File: rtl/neureka_tcdm_responder.sv
// -----------------------------------------------------------------------------
// neureka_tcdm_responder
// TCDM memory slave: byte-enabled writes, synchronous reads, one in-order
// response per handshake (writes answer with zero data), response FIFO with
// back-pressure through tcdm_gnt_o.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of in-flight and queued responses
//   tcdm_req_i/gnt_o       request handshake
//   tcdm_add_i             byte address (wraps modulo DEPTH words)
//   tcdm_wen_i             1 = read, 0 = write
//   tcdm_be_i, tcdm_data_i byte enables and write data
//   tcdm_id_i              request ID, echoed on tcdm_r_id_o
//   tcdm_r_valid_o/ready_i response handshake
//   tcdm_r_data_o, r_id_o  response payload from the FIFO head
// Build option:
//   NEUREKA_TCDM_RESPONDER_STALL_EN  adds an LFSR that randomly withholds grant.
// -----------------------------------------------------------------------------
module neureka_tcdm_responder
    import neureka_package::*;
#(
    parameter int unsigned DW         = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned AW         = 32,
    parameter int unsigned IW         = 8,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            tcdm_req_i,
    output logic            tcdm_gnt_o,
    input  logic [AW-1:0]   tcdm_add_i,
    input  logic            tcdm_wen_i,
    input  logic [DW/8-1:0] tcdm_be_i,
    input  logic [DW-1:0]   tcdm_data_i,
    input  logic [IW-1:0]   tcdm_id_i,
    output logic            tcdm_r_valid_o,
    input  logic            tcdm_r_ready_i,
    output logic [DW-1:0]   tcdm_r_data_o,
    output logic [IW-1:0]   tcdm_r_id_o
);

    localparam int unsigned NB  = DW/8;
    localparam int unsigned BW  = $clog2(NB);
    localparam int unsigned IXW = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH+1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } resp_t;

    logic [DW-1:0]  r_mem [DEPTH];

    // In-flight stage: the handshake of the previous cycle.
    logic           r_fl_valid;
    logic           r_fl_read;
    logic [IW-1:0]  r_fl_id;
    logic [DW-1:0]  r_fl_rdata;

    logic           w_hs;
    logic [IXW-1:0] w_idx;
    logic           w_room;
    logic           w_stall;
    logic [CW-1:0]  w_count;
    resp_t          w_push_entry;
    resp_t          w_head;
    logic           w_unused_addr;

    assign w_hs          = tcdm_req_i && tcdm_gnt_o;
    assign w_idx         = tcdm_add_i[BW +: IXW];
    assign w_unused_addr = ^tcdm_add_i;

    always_ff @(posedge clk_i) begin
        if (w_hs && !tcdm_wen_i) begin
            for (int b = 0; b < NB; b++) begin
                if (tcdm_be_i[b]) r_mem[w_idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
            end
        end
        if (w_hs && tcdm_wen_i) begin
            r_fl_rdata <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fl_valid <= 1'b0;
            r_fl_read  <= 1'b0;
            r_fl_id    <= '0;
        end else begin
            r_fl_valid <= w_hs && !clear_i;
            if (w_hs) begin
                r_fl_read <= tcdm_wen_i;
                r_fl_id   <= tcdm_id_i;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_push_entry    = '0;
        w_push_entry.id = r_fl_id;
        if (r_fl_read) w_push_entry.data = r_fl_rdata;
    end

    neureka_tcdm_resp_fifo #(
        .entry_t (resp_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_resp_fifo (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_clear      (clear_i),
        .i_push       (r_fl_valid),
        .i_push_entry (w_push_entry),
        .i_pop        (tcdm_r_ready_i),
        .o_valid      (tcdm_r_valid_o),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign tcdm_r_data_o = w_head.data;
    assign tcdm_r_id_o   = w_head.id;

    // Capacity counts the in-flight stage so its response always has a slot;
    // it uses registered state only, never the response ready.
    assign w_room = (int'(w_count) + int'(r_fl_valid)) < int'(FIFO_DEPTH);

`ifdef NEUREKA_TCDM_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign tcdm_gnt_o = rst_ni && !clear_i && !w_stall && w_room;

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
module tb_neureka_tcdm_responder;

    localparam int unsigned DW         = 256;
    localparam int unsigned AW         = 32;
    localparam int unsigned IW         = 8;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned NB         = DW/8;
    localparam int unsigned WIN        = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic            tcdm_req_i;
    logic            tcdm_gnt_o;
    logic [AW-1:0]   tcdm_add_i;
    logic            tcdm_wen_i;
    logic [NB-1:0]   tcdm_be_i;
    logic [DW-1:0]   tcdm_data_i;
    logic [IW-1:0]   tcdm_id_i;
    logic            tcdm_r_valid_o;
    logic            tcdm_r_ready_i;
    logic [DW-1:0]   tcdm_r_data_o;
    logic [IW-1:0]   tcdm_r_id_o;

    neureka_tcdm_responder #(
        .DW (DW), .AW (AW), .IW (IW), .DEPTH (DEPTH), .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .tcdm_req_i     (tcdm_req_i),
        .tcdm_gnt_o     (tcdm_gnt_o),
        .tcdm_add_i     (tcdm_add_i),
        .tcdm_wen_i     (tcdm_wen_i),
        .tcdm_be_i      (tcdm_be_i),
        .tcdm_data_i    (tcdm_data_i),
        .tcdm_id_i      (tcdm_id_i),
        .tcdm_r_valid_o (tcdm_r_valid_o),
        .tcdm_r_ready_i (tcdm_r_ready_i),
        .tcdm_r_data_o  (tcdm_r_data_o),
        .tcdm_r_id_o    (tcdm_r_id_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: byte-addressed memory image plus the queue of responses
    // owed to the requester, oldest first.
    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_grants = 0;
    logic          last_hs;
    logic          last_gnt_obs;
    string         phase = "reset";

`ifdef NEUREKA_TCDM_RESPONDER_STALL_EN
    logic [15:0]   model_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction
`endif

    function automatic int word_of(input logic [AW-1:0] add);
        return int'((longint'(add) / NB) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [AW-1:0] rand_addr(input int w);
        logic [AW-1:0] hi;
        hi = AW'($urandom) & ~AW'(DEPTH*NB - 1);
        return hi | AW'(w * NB) | AW'($urandom_range(0, NB-1));
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, update model.
    task automatic tick(input logic req, input logic wen, input logic [AW-1:0] add,
                        input logic [NB-1:0] be, input logic [DW-1:0] wdata,
                        input logic [IW-1:0] id, input logic ready, input logic clr);
        logic exp_gnt;
        int   w;
        exp_t e;
        tcdm_req_i     = req;
        tcdm_wen_i     = wen;
        tcdm_add_i     = add;
        tcdm_be_i      = be;
        tcdm_data_i    = wdata;
        tcdm_id_i      = id;
        tcdm_r_ready_i = ready;
        clear_i        = clr;
        @(negedge clk_i);
        exp_gnt = !clr && (exp_q.size() < FIFO_DEPTH);
`ifdef NEUREKA_TCDM_RESPONDER_STALL_EN
        if (model_lfsr[1:0] == 2'b00) exp_gnt = 1'b0;
`endif
        last_gnt_obs = tcdm_gnt_o;
        check("gnt", DW'(tcdm_gnt_o), DW'(exp_gnt));
        if (!clr) begin
            check("r_valid", DW'(tcdm_r_valid_o), DW'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("r_data", tcdm_r_data_o, exp_q[0].data);
                check("r_id", DW'(tcdm_r_id_o), DW'(exp_q[0].id));
            end
        end
        last_hs = req && exp_gnt;
        if (clr) begin
            exp_q.delete();
        end else begin
            if (ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (last_hs) begin
                w = word_of(add);
                if (!wen) begin
                    for (int b = 0; b < NB; b++)
                        if (be[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
                end
                e.data = wen ? model_mem[w] : '0;
                e.id   = id;
                exp_q.push_back(e);
                n_grants++;
            end
        end
        @(posedge clk_i);
`ifdef NEUREKA_TCDM_RESPONDER_STALL_EN
        model_lfsr = lfsr_step(model_lfsr);
`endif
        #1;
    endtask

    task automatic idle(input logic ready);
        tick(1'b0, 1'b1, '0, '0, '0, '0, ready, 1'b0);
    endtask

    // Retry one request until granted (bounded), responses drained freely.
    task automatic xfer(input logic wen, input logic [AW-1:0] add, input logic [NB-1:0] be,
                        input logic [DW-1:0] d, input logic [IW-1:0] id);
        int tries;
        tries = 0;
        do begin
            tick(1'b1, wen, add, be, d, id, 1'b1, 1'b0);
            tries++;
        end while (!last_hs && tries < 32);
        check("xfer_granted", DW'(last_gnt_obs), DW'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        tcdm_req_i     = 1'b0;
        clear_i        = 1'b0;
        tcdm_r_ready_i = 1'b0;
        rst_ni         = 1'b0;
        @(negedge clk_i);
        check("rst_r_valid", DW'(tcdm_r_valid_o), DW'(0));
        check("rst_r_data", tcdm_r_data_o, DW'(0));
        check("rst_r_id", DW'(tcdm_r_id_o), DW'(0));
        check("rst_gnt", DW'(tcdm_gnt_o), DW'(0));
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
`ifdef NEUREKA_TCDM_RESPONDER_STALL_EN
        model_lfsr = 16'hACE1;
`endif
    endtask

    initial begin
        tcdm_add_i  = '0;
        tcdm_wen_i  = 1'b1;
        tcdm_be_i   = '0;
        tcdm_data_i = '0;
        tcdm_id_i   = '0;
        do_reset();

        phase = "init";
        for (int w = 0; w < WIN; w++) xfer(1'b0, AW'(w * NB), '1, rand_word(), IW'(w));
        drain();

        phase = "write_read_0x40";
        xfer(1'b0, AW'('h40), '1, DW'(32'hDEADBEEF), IW'(1));
        xfer(1'b1, AW'('h40), '0, '0, IW'(5));
        drain();

        phase = "byte_enable";
        xfer(1'b0, AW'(3 * NB), '1, '1, IW'(2));
        xfer(1'b0, AW'(3 * NB), NB'(8'h0F), rand_word(), IW'(3));
        xfer(1'b1, AW'(3 * NB), '0, '0, IW'(4));
        drain();

        phase = "backpressure";
        n_grants = 0;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, AW'((i % WIN) * NB), '0, '0, IW'(i), 1'b0, 1'b0);
`ifndef NEUREKA_TCDM_RESPONDER_STALL_EN
        check("grant_count", DW'(n_grants), DW'(FIFO_DEPTH));
`endif
        drain();

        phase = "wrap";
        xfer(1'b1, AW'(DEPTH * NB + 'h20), '0, '0, IW'(9));
        drain();

        phase = "clear";
        for (int i = 0; i < 3; i++) xfer(1'b1, AW'(i * NB), '0, '0, IW'(20 + i));
        tcdm_r_ready_i = 1'b0;
        tick(1'b1, 1'b0, AW'(4 * NB), '1, DW'(32'h1234), IW'(30), 1'b0, 1'b1);
        idle(1'b1);
        for (int w = 2; w <= 4; w++) xfer(1'b1, AW'(w * NB), '0, '0, IW'(40 + w));
        drain();

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom), rand_addr($urandom_range(0, WIN-1)),
                 NB'({$urandom, $urandom}), rand_word(), IW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        drain();

        phase = "reset_mid";
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, AW'(i * NB), '0, '0, IW'(i), 1'b0, 1'b0);
        do_reset();
        idle(1'b1);
        for (int w = 0; w < 4; w++) xfer(1'b1, AW'(w * NB), '0, '0, IW'(60 + w));
        drain();

`ifdef NEUREKA_TCDM_RESPONDER_STALL_EN
        phase = "stall";
        n_grants = 0;
        for (int i = 0; i < 1000; i++)
            tick(1'b1, 1'b1, AW'($urandom_range(0, WIN-1) * NB), '0, '0, IW'(i), 1'b1, 1'b0);
        check("stall_fraction_ok", DW'((1000 - n_grants) >= 150 && (1000 - n_grants) <= 350), DW'(1));
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
